// File: rtl/tl_arbiter_fsm.sv
// Transaction-layer output mux control: one-hot FSM plus round-robin arbiter.
// Drives mux state/idx/req, FIFO pop strobes and the latched threshold.
//
// Ports:
//   clk, reset_L       - clock (posedge), async active-low reset
//   init               - enter/stay in INIT
//   umbral_in          - threshold sampled while in INIT
//   empty[NUM_Q]       - per-FIFO empty flags
//   af_out             - downstream almost-full (back-pressure)
//   state[4]           - one-hot RESET/INIT/IDLE/ACTIVE
//   idx, req, pop      - granted queue, mux capture request, FIFO pop strobe
//   umbral_out         - latched threshold to the FIFOs
//   idle_out           - IDLE with all FIFOs empty
module tl_arbiter_fsm #(
    parameter int NUM_Q = 5,
    parameter int IDX_W = 3,
    parameter int THR_W = 3
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic [THR_W-1:0] umbral_in,
    input  logic [NUM_Q-1:0] empty,
    input  logic             af_out,
    output logic [3:0]       state,
    output logic [IDX_W-1:0] idx,
    output logic             req,
    output logic [NUM_Q-1:0] pop,
    output logic [THR_W-1:0] umbral_out,
    output logic             idle_out
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_last_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic [NUM_Q-1:0] r_pop;
    logic [NUM_Q-1:0] w_pop_nxt;
    logic [THR_W-1:0] r_umbral;
    logic [THR_W-1:0] w_umbral_nxt;
    logic             r_idle;
    logic             w_idle_nxt;

    logic [NUM_Q-1:0] w_elig;
    logic             w_found;
    logic [IDX_W-1:0] w_grant;
    logic [IDX_W:0]   w_cand;

    // A queue popped last cycle still shows its old empty flag, so it
    // is masked out for one cycle to avoid popping an empty FIFO.
    assign w_elig = ~empty & ~r_pop;

    // Round-robin search starting just after the last granted queue.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        w_cand  = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            w_cand = {1'b0, r_last} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_Q))
                w_cand = w_cand - (IDX_W+1)'(NUM_Q);
            if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_last_nxt   = r_last;
        w_req_nxt    = 1'b0;
        w_pop_nxt    = '0;
        w_umbral_nxt = r_umbral;
        w_idle_nxt   = 1'b0;
        unique case (r_state)
            ST_RESET: w_state_nxt = ST_INIT;
            ST_INIT: begin
                w_umbral_nxt = umbral_in;
                if (!init)
                    w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (init) begin
                    w_state_nxt = ST_INIT;
                end else if (af_out) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_found) begin
                    w_idx_nxt          = w_grant;
                    w_last_nxt         = w_grant;
                    w_req_nxt          = 1'b1;
                    w_pop_nxt[w_grant] = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (init)
                    w_state_nxt = ST_INIT;
                else if (!af_out)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_RESET;
        endcase
        w_idle_nxt = (w_state_nxt == ST_IDLE) && !w_req_nxt && (&empty);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= ST_RESET;
            r_idx    <= '0;
            r_last   <= IDX_W'(NUM_Q-1);
            r_req    <= 1'b0;
            r_pop    <= '0;
            r_umbral <= '0;
            r_idle   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_last   <= w_last_nxt;
            r_req    <= w_req_nxt;
            r_pop    <= w_pop_nxt;
            r_umbral <= w_umbral_nxt;
            r_idle   <= w_idle_nxt;
        end
    end

    assign state      = r_state;
    assign idx        = r_idx;
    assign req        = r_req;
    assign pop        = r_pop;
    assign umbral_out = r_umbral;
    assign idle_out   = r_idle;

endmodule

// File: tb/tb_tl_arbiter_fsm.sv
// Self-checking bench for tl_arbiter_fsm: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_tl_arbiter_fsm;

    localparam int NUM_Q = 5;
    localparam int IDX_W = 3;
    localparam int THR_W = 3;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;

    logic             clk;
    logic             reset_L;
    logic             init;
    logic [THR_W-1:0] umbral_in;
    logic [NUM_Q-1:0] empty;
    logic             af_out;
    logic [3:0]       state;
    logic [IDX_W-1:0] idx;
    logic             req;
    logic [NUM_Q-1:0] pop;
    logic [THR_W-1:0] umbral_out;
    logic             idle_out;

    int n_chk;
    int n_pass;

    int m_state;
    int m_idx;
    int m_last;
    int m_req;
    int m_pop;
    int m_umb;
    int m_idle;
    int m_prevg;

    tl_arbiter_fsm #(
        .NUM_Q(NUM_Q),
        .IDX_W(IDX_W),
        .THR_W(THR_W)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .init      (init),
        .umbral_in (umbral_in),
        .empty     (empty),
        .af_out    (af_out),
        .state     (state),
        .idx       (idx),
        .req       (req),
        .pop       (pop),
        .umbral_out(umbral_out),
        .idle_out  (idle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_state = M_RESET;
        m_idx   = 0;
        m_last  = NUM_Q - 1;
        m_req   = 0;
        m_pop   = 0;
        m_umb   = 0;
        m_idle  = 0;
        m_prevg = -1;
    endtask

    task automatic model_step();
        int g;
        int ns;
        int q;
        g  = -1;
        ns = m_state;
        case (m_state)
            M_RESET: ns = M_INIT;
            M_INIT: begin
                m_umb = int'(umbral_in);
                ns = init ? M_INIT : M_IDLE;
            end
            M_IDLE: begin
                if (init) ns = M_INIT;
                else if (af_out) ns = M_ACTIVE;
                else begin
                    for (int k = 1; k <= NUM_Q; k++) begin
                        q = (m_last + k) % NUM_Q;
                        if (g < 0 && !empty[q] && q != m_prevg) g = q;
                    end
                end
            end
            default: ns = init ? M_INIT : (af_out ? M_ACTIVE : M_IDLE);
        endcase
        if (g >= 0) begin
            m_idx  = g;
            m_last = g;
            m_req  = 1;
            m_pop  = 1 << g;
        end else begin
            m_req = 0;
            m_pop = 0;
        end
        m_idle  = (ns == M_IDLE && g < 0 && empty == 5'h1f) ? 1 : 0;
        m_prevg = g;
        m_state = ns;
    endtask

    task automatic check_all();
        chk("state", int'(state), 1 << m_state);
        chk("idx", int'(idx), m_idx);
        chk("req", int'(req), m_req);
        chk("pop", int'(pop), m_pop);
        chk("umbral", int'(umbral_out), m_umb);
        chk("idle", int'(idle_out), m_idle);
        chk("pop_1hot", int'($onehot0(pop)), 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_L) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int seen;
        int budget;
        n_chk     = 0;
        n_pass    = 0;
        reset_L   = 1'b0;
        init      = 1'b1;
        umbral_in = 3'd3;
        empty     = 5'h1f;
        af_out    = 1'b0;
        model_reset();

        // Reset values, then INIT with threshold 3, then IDLE.
        @(negedge clk);
        check_all();
        reset_L = 1'b1;
        repeat (4) cycle();
        init = 1'b0;
        cycle();
        chk("umb_is_3", int'(umbral_out), 3);
        chk("idle_set", int'(idle_out), 1);
        chk("st_idle", int'(state), 4);
        cycle();

        // All queues busy: rotation 0,1,2,3,4,0.
        empty = 5'h00;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("rr_idx", int'(idx), i % NUM_Q);
        end

        // Only queue 2 busy: grants every other cycle.
        empty = 5'b11011;
        repeat (6) cycle();

        // Back-pressure during streaming.
        empty = 5'h00;
        repeat (2) cycle();
        af_out = 1'b1;
        repeat (3) cycle();
        chk("st_active", int'(state), 8);
        af_out = 1'b0;
        repeat (4) cycle();

        // Re-init while grants are flowing.
        init      = 1'b1;
        umbral_in = 3'd5;
        cycle();
        chk("reinit_req", int'(req), 0);
        cycle();
        init = 1'b0;
        repeat (3) cycle();
        chk("umb_is_5", int'(umbral_out), 5);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            empty     = NUM_Q'($urandom_range(0, 31));
            af_out    = ($urandom_range(0, 3) == 0);
            init      = ($urandom_range(0, 39) == 0);
            umbral_in = THR_W'($urandom_range(0, 7));
            cycle();
        end

        // Async reset while a grant is on the outputs.
        init   = 1'b0;
        af_out = 1'b0;
        empty  = 5'h00;
        seen   = 0;
        budget = 0;
        while (!seen && budget < 20) begin
            cycle();
            budget++;
            if (m_req == 1) seen = 1;
        end
        chk("grant_seen", seen, 1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("async_state", int'(state), 1);
        chk("async_req", int'(req), 0);
        chk("async_pop", int'(pop), 0);
        model_reset();
        @(negedge clk);
        check_all();
        reset_L = 1'b1;
        repeat (8) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tl_arbiter_fsm.md
Name: tl_arbiter_fsm

Overview:
- Control FSM and round-robin arbiter for the transaction-layer output mux.
- Drives the mux one-hot `state`, `idx` and `req`, and the `pop` strobes of five show-ahead (first-word-fall-through) source FIFOs.
- Applies downstream back-pressure from the destination almost-full flag.
- Latches the almost-full/empty threshold ("umbral") that is distributed to the FIFOs during INIT.

Parameters:
- NUM_Q, 5, number of source queues; the mux supports 5.
- IDX_W, 3, width of `idx`.
- THR_W, 3, width of the threshold bus.

Ports:
- clk  in  1  clock; all logic on the posedge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  request to enter or stay in INIT.
- umbral_in  in  THR_W  threshold value sampled during INIT.
- empty  in  NUM_Q  per-FIFO empty flag; bit i = FIFO i.
- af_out  in  1  downstream almost-full.
- state  out  4  one-hot: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
- idx  out  IDX_W  granted queue index, 0..NUM_Q-1.
- req  out  1  mux capture request.
- pop  out  NUM_Q  one-hot FIFO pop strobe.
- umbral_out  out  THR_W  latched threshold to the FIFOs.
- idle_out  out  1  high when state=IDLE and all FIFOs are empty.

Behaviour:
- All outputs are registered. reset_L=0 asynchronously forces:
  - state=0001, idx=0, req=0, pop=0, umbral_out=0, idle_out=0
  - round-robin pointer last=NUM_Q-1, so the first search starts at queue 0.
- RESET: on the first posedge with reset_L=1, go to INIT.
- INIT:
  - Each cycle: umbral_out<=umbral_in; req=0; pop=0.
  - Stay while init=1.
  - When init=0, go to IDLE; umbral_out holds the last sampled value.
- IDLE:
  - A queue is eligible if empty[i]=0 AND i was not granted in the immediately preceding cycle. The no-back-to-back rule covers the one-cycle lag between pop and the empty flag updating.
  - If af_out=0 and any queue is eligible: grant g = first eligible queue searching last+1, last+2, … mod NUM_Q. Register pop[g]=1, idx=g, req=1 for exactly one cycle, and set last=g.
  - Otherwise req=0 and pop=0; idx and last hold.
  - The mux sees req=1 with state=IDLE during cycle k and captures at edge k+1. The FIFO pops at the same edge, and show-ahead data is stable during cycle k.
- ACTIVE (back-pressure stall):
  - Entered from IDLE when af_out=1.
  - req=0 and pop=0 throughout.
  - Returns to IDLE on the first edge that samples af_out=0.
  - A grant registered at the edge that enters ACTIVE is not possible: af_out is checked before granting. One grant can still be in flight when af_out rises, so the destination threshold must allow one word of slack.
- Transition priority: reset_L=0 > init=1 (from IDLE or ACTIVE go to INIT; any pending req/pop clears to 0 at that edge) > af_out > arbitration.
- idle_out is registered: 1 when next state=IDLE, no grant is issued and empty=all ones.
- Invariants:
  - pop is always zero or one-hot.
  - req=1 if and only if pop≠0, and when req=1, pop[idx]=1.
  - state is always exactly one-hot.
- Throughput:
  - Up to one grant per cycle across different queues.
  - A single busy queue gets at most one grant per two cycles.
- Reset mid-transfer aborts immediately with no pop. The FIFO contents are not this block's concern.

Test Plan:
- Reset then init: reset_L low, init=1, umbral_in=3 for 4 cycles, then init=0 → state 0001→0010→0100 on successive edges, umbral_out=3, idle_out=1 with all FIFOs empty.
- Round robin: all five FIFOs non-empty, af_out=0 → idx sequence 0,1,2,3,4,0 on consecutive cycles, req=1 each cycle, pop=00001,00010,… and always one-hot.
- Single queue: only empty[2]=0 → req/pop[2] asserted every other cycle with idx=2; no back-to-back grant.
- Back-pressure: af_out=1 during streaming → state=1000 next edge and req=0 while high; af_out=0 → IDLE and grants resume at the next queue after last.
- Re-init: init=1 while in IDLE with grants pending → next edge state=0010, req=0, pop=0, new umbral_in latched.
- Async reset mid-grant: drop reset_L between edges while req=1 → state=0001, req=0, pop=0 immediately, without waiting for clk.
